fc3_layer: RTL and testbench



---
 rtl/fc3_pkg.sv | 26 ++
 rtl/fc3_if.sv | 28 ++
 rtl/fc3_round_sat.sv | 37 +++
 rtl/fc3_layer.sv | 106 ++++++++++
 tb/tb_fc3_layer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fc3_pkg.sv
// Shared definitions for the third fully-connected layer engine:
// FSM state encoding, accumulator width, default geometry and Q16.16 constants.
package fc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } fc3_state_e;

  localparam int ACC_W         = 72;
  localparam int DEF_IN_LEN    = 64;
  localparam int DEF_OUT_LEN   = 10;
  localparam int DEF_FRAC_BITS = 16;
  localparam int DEF_ADDR_W    = 16;

  localparam logic [31:0] ONE     = 32'h0001_0000;
  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  // Saturation bounds sign-extended to the accumulator width
  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = {{(ACC_W-32){1'b0}}, SAT_MAX};
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = {{(ACC_W-32){1'b1}}, SAT_MIN};

endpackage

// File: rtl/fc3_if.sv
// Sequencer / memory-side bus of the fc3 engine.
// slave: the engine; master: sequencer plus activation/weight/output memories.
interface fc3_if #(
  parameter int ADDR_W = 16
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        act_read_addr;
  logic signed [31:0]       act_data;
  logic [ADDR_W-1:0]        weight_read_addr;
  logic signed [31:0]       weight_data;
  logic [ADDR_W-1:0]        out_write_addr;
  logic signed [31:0]       out_data;
  logic                     out_write_enable;

  modport master (
    output start, act_data, weight_data,
    input  busy, done, act_read_addr, weight_read_addr,
           out_write_addr, out_data, out_write_enable
  );

  modport slave (
    input  start, act_data, weight_data,
    output busy, done, act_read_addr, weight_read_addr,
           out_write_addr, out_data, out_write_enable
  );
endinterface

// File: rtl/fc3_round_sat.sv
// Accumulator to Q16.16 result conversion: optional round-half-up,
// arithmetic right shift by FRAC_BITS, clamp to the signed 32-bit range.
// Build option: FC3_ROUND_EN enables rounding; otherwise truncation toward -inf.
module fc3_round_sat
  import fc3_pkg::*;
#(
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic        [31:0]      o_data
);

`ifdef FC3_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (FRAC_BITS - 1);
`endif

  logic signed [ACC_W-1:0] w_rnd;
  logic signed [ACC_W-1:0] w_shf;

  // Round (if enabled), shift, then saturate
  always_comb begin
`ifdef FC3_ROUND_EN
    w_rnd = i_acc + RND_HALF;
`else
    w_rnd = i_acc;
`endif
    w_shf = w_rnd >>> FRAC_BITS;
    if (w_shf > ACC_SAT_MAX) begin
      o_data = SAT_MAX;
    end else if (w_shf < ACC_SAT_MIN) begin
      o_data = SAT_MIN;
    end else begin
      o_data = w_shf[31:0];
    end
  end

endmodule

// File: rtl/fc3_layer.sv
// Third fully-connected layer: OUT_LEN dot products of IN_LEN Q16.16 terms,
// one MAC per cycle, each result saturated and written to the output memory.
// Build option: FC3_ROUND_EN (round-half-up before the shift, see fc3_round_sat).
module fc3_layer
  import fc3_pkg::*;
#(
  parameter int IN_LEN    = DEF_IN_LEN,
  parameter int OUT_LEN   = DEF_OUT_LEN,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic  clk,
  input  logic  rst_n,
  fc3_if.slave  bus
);

  fc3_state_e              r_state;
  logic [ADDR_W-1:0]       r_i;
  logic [ADDR_W-1:0]       r_o;
  logic [ADDR_W-1:0]       r_waddr;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_we;

  logic signed [63:0]      w_prod;
  logic [31:0]             w_sat;

  assign w_prod = bus.act_data * bus.weight_data;

  fc3_round_sat #(
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .i_acc  (r_acc),
    .o_data (w_sat)
  );

  // Control FSM, counters and accumulator.
  // r_waddr runs 0..IN_LEN*OUT_LEN-1 across all neurons: since weights are
  // row-major and i restarts with o++, it always equals o*IN_LEN+i in MAC,
  // avoiding a multiplier in the address path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_o     <= '0;
      r_waddr <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_i     <= '0;
            r_o     <= '0;
            r_waddr <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc   <= r_acc + ACC_W'(w_prod);
          r_waddr <= r_waddr + 1'b1;
          if (r_i == ADDR_W'(IN_LEN - 1)) begin
            r_we    <= 1'b1;
            r_state <= ST_WRITE;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        ST_WRITE: begin
          r_acc <= '0;
          r_i   <= '0;
          r_we  <= 1'b0;
          if (r_o == ADDR_W'(OUT_LEN - 1)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_o     <= r_o + 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.out_write_enable = r_we;
  assign bus.act_read_addr    = (r_state == ST_MAC)   ? r_i     : '0;
  assign bus.weight_read_addr = (r_state == ST_MAC)   ? r_waddr : '0;
  assign bus.out_write_addr   = (r_state == ST_WRITE) ? r_o     : '0;
  assign bus.out_data         = (r_state == ST_WRITE) ? w_sat   : '0;

endmodule

// File: tb/tb_fc3_layer.sv
// Directed self-checking bench for fc3_layer with behavioural memories.
module tb_fc3_layer;
  import fc3_pkg::*;

  logic clk;
  logic rst_n;

  fc3_if #(.ADDR_W(16)) bus ();

  fc3_layer #(
    .IN_LEN    (64),
    .OUT_LEN   (10),
    .FRAC_BITS (16),
    .ADDR_W    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] act_mem [64];
  logic [31:0] w_mem   [640];

  always_comb begin
    bus.act_data    = act_mem[bus.act_read_addr[5:0]];
    bus.weight_data = (bus.weight_read_addr < 16'd640) ? w_mem[bus.weight_read_addr] : 32'h0;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: cycle count, write log, done pulses, MAC address sequence
  int          cyc = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  int          n_mac = 0;
  int          n_addr_err = 0;
  int          exp_wa = 0;
  int          wr_edge [256];
  logic [15:0] wr_addr [256];
  logic [31:0] wr_data [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_write_enable) begin
      if (n_wr < 256) begin
        wr_edge[n_wr] <= cyc + 1;
        wr_addr[n_wr] <= bus.out_write_addr;
        wr_data[n_wr] <= bus.out_data;
      end
      n_wr <= n_wr + 1;
    end
    if (bus.done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (!bus.busy) begin
      exp_wa <= 0;
    end else if (!bus.out_write_enable && !bus.done) begin
      n_mac  <= n_mac + 1;
      exp_wa <= exp_wa + 1;
      if (int'(bus.weight_read_addr) != exp_wa || int'(bus.act_read_addr) != (exp_wa % 64))
        n_addr_err <= n_addr_err + 1;
    end
  end

  task automatic fill_const(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 64; i++) act_mem[i] = a;
    for (int i = 0; i < 640; i++) w_mem[i] = w;
  endtask

  task automatic do_start(output int e0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int e0, input int bd);
    while (n_done == bd && cyc < e0 + 1000) @(negedge clk);
    chk({tag, "_done_seen"}, 64'(n_done != bd), 64'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int e0, input int bw, input int bd,
                           input logic [31:0] ev [10]);
    chk({tag, "_nwrites"}, 64'(n_wr - bw), 64'd10);
    chk({tag, "_ndone"}, 64'(n_done - bd), 64'd1);
    chk({tag, "_done_cyc"}, 64'(done_cyc - e0), 64'd650);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 64'(wr_addr[bw+k]), 64'(k));
      chk($sformatf("%s_data%0d", tag, k), 64'(wr_data[bw+k]), 64'(ev[k]));
      chk($sformatf("%s_edge%0d", tag, k), 64'(wr_edge[bw+k] - e0), 64'(65 * (k + 1)));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_we"}, 64'(bus.out_write_enable), 64'd0);
    chk({tag, "_aaddr"}, 64'(bus.act_read_addr), 64'd0);
    chk({tag, "_waddr"}, 64'(bus.weight_read_addr), 64'd0);
    chk({tag, "_oaddr"}, 64'(bus.out_write_addr), 64'd0);
    chk({tag, "_odata"}, 64'(bus.out_data), 64'd0);
  endtask

  initial begin
    int          e0, bw, bd, bm, be;
    logic [31:0] ev [10];

    rst_n     = 1'b0;
    bus.start = 1'b0;
    fill_const(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unit values: 64 * 1.0 * 1.0 = 64.0
    fill_const(ONE, ONE);
    for (int k = 0; k < 10; k++) ev[k] = 32'h0040_0000;
    bw = n_wr; bd = n_done;
    do_start(e0);
    wait_done("unit", e0, bd);
    check_run("unit", e0, bw, bd, ev);

    // Selector weights: out[o] = act[o] = o.0
    for (int i = 0; i < 64; i++) act_mem[i] = 32'(i) << 16;
    for (int o = 0; o < 10; o++)
      for (int i = 0; i < 64; i++) w_mem[o*64+i] = (i == o) ? ONE : 32'h0;
    for (int k = 0; k < 10; k++) ev[k] = 32'(k) << 16;
    bw = n_wr; bd = n_done; bm = n_mac; be = n_addr_err;
    do_start(e0);
    wait_done("sel", e0, bd);
    check_run("sel", e0, bw, bd, ev);
    chk("sel_mac_cycles", 64'(n_mac - bm), 64'd640);
    chk("sel_addr_errs", 64'(n_addr_err - be), 64'd0);

    // Positive saturation
    fill_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    for (int k = 0; k < 10; k++) ev[k] = SAT_MAX;
    bw = n_wr; bd = n_done;
    do_start(e0);
    wait_done("satp", e0, bd);
    check_run("satp", e0, bw, bd, ev);

    // Negative saturation
    fill_const(32'h7FFF_FFFF, 32'h8000_0001);
    for (int k = 0; k < 10; k++) ev[k] = SAT_MIN;
    bw = n_wr; bd = n_done;
    do_start(e0);
    wait_done("satn", e0, bd);
    check_run("satn", e0, bw, bd, ev);

    // Rounding: acc = 0x8000 -> 0.5 LSB after the shift
    fill_const(32'h0, 32'h0);
    act_mem[0] = 32'h1;
    w_mem[0]   = 32'h0000_8000;
    for (int k = 0; k < 10; k++) ev[k] = 32'h0;
`ifdef FC3_ROUND_EN
    ev[0] = 32'h1;
`endif
    bw = n_wr; bd = n_done;
    do_start(e0);
    wait_done("rnd", e0, bd);
    check_run("rnd", e0, bw, bd, ev);

    // start re-pulsed mid-run must be ignored
    fill_const(ONE, ONE);
    for (int k = 0; k < 10; k++) ev[k] = 32'h0040_0000;
    bw = n_wr; bd = n_done;
    do_start(e0);
    while (cyc < e0 + 200) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("restart", e0, bd);
    check_run("restart", e0, bw, bd, ev);
    chk("restart_no_rerun", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-run aborts with no further writes
    bw = n_wr; bd = n_done;
    do_start(e0);
    while (cyc < e0 + 100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("abort");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (800) @(negedge clk);
    chk("abort_nwrites", 64'(n_wr - bw), 64'd1);
    chk("abort_ndone", 64'(n_done - bd), 64'd0);
    chk("abort_idle", 64'(bus.busy), 64'd0);

    // Fresh run after the abort
    bw = n_wr; bd = n_done;
    do_start(e0);
    wait_done("after", e0, bd);
    check_run("after", e0, bw, bd, ev);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
